// File: rtl/dkong3_obj_dma.sv
// rtl/dkong3_obj_dma.sv - object-RAM DMA: copies a CPU-memory block into object RAM, one byte per slot
module dkong3_obj_dma #(
    parameter logic [9:0] DST_BASE    = 10'h000,
    parameter logic [7:0] REQ_TIMEOUT = 8'd255
) (
    input  logic        I_CLK_24M,
    input  logic        RST_4L,
    input  logic        I_SLOT_CE,
    input  logic        I_START,
    input  logic [15:0] I_SRC_BASE,
    input  logic [9:0]  I_LEN,
    input  logic        I_BUSAK_n,
    output logic        O_BUSRQ_n,
    output logic [15:0] O_SRC_A,
    output logic        O_SRC_RD_n,
    input  logic [7:0]  I_SRC_D,
    output logic [9:0]  O_OBJ_DMA_A,
    output logic [7:0]  O_OBJ_DMA_D,
    output logic        O_OBJ_DMA_CE,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic        O_ABORT
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_READ, S_WRITE, S_RELEASE, S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] src_q, src_d;
    logic [9:0]  dst_q, dst_d;
    logic [9:0]  rem_q, rem_d;
    logic [7:0]  wait_q, wait_d;
    logic [7:0]  wait_inc;
    logic        stop_q, stop_d;

    logic        busrq_n_q, busrq_n_d;
    logic        rd_n_q, rd_n_d;
    logic [7:0]  dma_d_q, dma_d_d;
    logic        ce_q, ce_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    assign wait_inc = wait_q + 8'd1;

    // State, counters and registered outputs; every output is a flop
    always_ff @(posedge I_CLK_24M or negedge RST_4L) begin
        if (!RST_4L) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            wait_q    <= '0;
            stop_q    <= 1'b0;
            busrq_n_q <= 1'b1;
            rd_n_q    <= 1'b1;
            dma_d_q   <= '0;
            ce_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            wait_q    <= wait_d;
            stop_q    <= stop_d;
            busrq_n_q <= busrq_n_d;
            rd_n_q    <= rd_n_d;
            dma_d_q   <= dma_d_d;
            ce_q      <= ce_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    // Next state plus counter updates; stop_q remembers a bus loss during READ/WRITE
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        wait_d  = wait_q;
        stop_d  = stop_q;
        case (state_q)
            S_IDLE: begin
                if (I_START) begin
                    if (I_LEN != 10'd0) begin
                        state_d = S_REQ;
                        src_d   = I_SRC_BASE;
                        dst_d   = DST_BASE;
                        rem_d   = I_LEN;
                        wait_d  = 8'd0;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_REQ: begin
                if (I_SLOT_CE) begin
                    if (!I_BUSAK_n) begin
                        state_d = S_READ;
                    end else begin
                        wait_d = wait_inc;
                        if (wait_inc == REQ_TIMEOUT) begin
                            state_d = S_RELEASE;
                        end
                    end
                end
            end
            S_READ: begin
                if (I_BUSAK_n) begin
                    stop_d = 1'b1;
                end
                if (I_SLOT_CE) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                src_d = src_q + 16'd1;
                dst_d = dst_q + 10'd1;
                rem_d = rem_q - 10'd1;
                if (I_BUSAK_n) begin
                    stop_d = 1'b1;
                end
                if ((rem_q > 10'd1) && !stop_q && !I_BUSAK_n) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (I_BUSAK_n) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values derived from the next state so each flop lines up with its state
    always_comb begin
        busrq_n_d = !((state_d == S_REQ) || (state_d == S_READ) || (state_d == S_WRITE));
        rd_n_d    = (state_d != S_READ);
        ce_d      = (state_d == S_WRITE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FIN);
        abort_d   = (state_q == S_REQ) && (state_d == S_RELEASE);
        dma_d_d   = dma_d_q;
        if ((state_q == S_READ) && I_SLOT_CE) begin
            dma_d_d = I_SRC_D;
        end
    end

    assign O_BUSRQ_n    = busrq_n_q;
    assign O_SRC_A      = src_q;
    assign O_SRC_RD_n   = rd_n_q;
    assign O_OBJ_DMA_A  = dst_q;
    assign O_OBJ_DMA_D  = dma_d_q;
    assign O_OBJ_DMA_CE = ce_q;
    assign O_BUSY       = busy_q;
    assign O_DONE       = done_q;
    assign O_ABORT      = abort_q;

endmodule

// File: tb/tb_dkong3_obj_dma.sv
// tb/tb_dkong3_obj_dma.sv - directed self-checking bench for dkong3_obj_dma
module tb_dkong3_obj_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slot = 1'b0;
    logic        start = 1'b0;
    logic        start_w = 1'b0;
    logic        busak_force = 1'b0;
    logic [15:0] src_base = '0;
    logic [9:0]  len = '0;

    logic        busak_n, busrq_n, rd_n, ce, busy, done, abort;
    logic [15:0] src_a;
    logic [7:0]  src_d, dma_d;
    logic [9:0]  dma_a;

    logic        busak_n_w, busrq_n_w, rd_n_w, ce_w, busy_w, done_w, abort_w;
    logic [15:0] src_a_w;
    logic [7:0]  src_d_w, dma_d_w;
    logic [9:0]  dma_a_w;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign busak_n   = busak_force | busrq_n;
    assign src_d     = mem(src_a);
    assign busak_n_w = busrq_n_w;
    assign src_d_w   = mem(src_a_w);

    dkong3_obj_dma u_dut (
        .I_CLK_24M(clk), .RST_4L(rst_n), .I_SLOT_CE(slot), .I_START(start),
        .I_SRC_BASE(src_base), .I_LEN(len), .I_BUSAK_n(busak_n), .O_BUSRQ_n(busrq_n),
        .O_SRC_A(src_a), .O_SRC_RD_n(rd_n), .I_SRC_D(src_d), .O_OBJ_DMA_A(dma_a),
        .O_OBJ_DMA_D(dma_d), .O_OBJ_DMA_CE(ce), .O_BUSY(busy), .O_DONE(done), .O_ABORT(abort)
    );

    dkong3_obj_dma #(.DST_BASE(10'h3FE)) u_dut_wrap (
        .I_CLK_24M(clk), .RST_4L(rst_n), .I_SLOT_CE(slot), .I_START(start_w),
        .I_SRC_BASE(src_base), .I_LEN(len), .I_BUSAK_n(busak_n_w), .O_BUSRQ_n(busrq_n_w),
        .O_SRC_A(src_a_w), .O_SRC_RD_n(rd_n_w), .I_SRC_D(src_d_w), .O_OBJ_DMA_A(dma_a_w),
        .O_OBJ_DMA_D(dma_d_w), .O_OBJ_DMA_CE(ce_w), .O_BUSY(busy_w), .O_DONE(done_w), .O_ABORT(abort_w)
    );

    always #5 clk = ~clk;

    // Slot enable: one clock wide, every 8 clocks
    initial begin
        forever begin
            repeat (7) @(posedge clk);
            #1 slot = 1'b1;
            @(posedge clk);
            #1 slot = 1'b0;
        end
    end

    logic [9:0]  qa[$];
    logic [15:0] qs[$];
    logic [7:0]  qd[$];
    logic [9:0]  wqa[$];
    logic [15:0] wqs[$];
    logic [7:0]  wqd[$];
    int n_done, n_abort, n_slot, slot_at_abort, wn_done;
    bit rq_seen;

    always @(negedge clk) begin
        if (ce) begin
            qa.push_back(dma_a); qs.push_back(src_a); qd.push_back(dma_d);
        end
        if (ce_w) begin
            wqa.push_back(dma_a_w); wqs.push_back(src_a_w); wqd.push_back(dma_d_w);
        end
        if (done) n_done++;
        if (done_w) wn_done++;
        if (abort) begin
            n_abort++;
            slot_at_abort = n_slot;
        end
        if (busy && slot) n_slot++;
        if (!busrq_n) rq_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        qa.delete(); qs.delete(); qd.delete();
        wqa.delete(); wqs.delete(); wqd.delete();
        n_done = 0; n_abort = 0; n_slot = 0; slot_at_abort = -1; wn_done = 0;
        rq_seen = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] s, input logic [9:0] l);
        @(posedge clk);
        #1 src_base = s; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int c = 0;
        while (n_done < 1 && c < lim) begin
            @(posedge clk);
            c++;
        end
        @(negedge clk);
        chk(tag, (n_done >= 1) ? 32'd1 : 32'd0, 32'd1);
    endtask

    logic [9:0]  wa_exp[4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [15:0] ws_exp[4] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};

    initial begin
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busrq_n", busrq_n, 1);
        chk("rst_rd_n", rd_n, 1);
        chk("rst_ce", ce, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_abort", abort, 0);
        chk("rst_src_a", src_a, 0);
        chk("rst_dma_a", dma_a, 0);
        chk("rst_dma_d", dma_d, 0);
        @(negedge clk) rst_n = 1'b1;

        // zero length
        clear_mon();
        pulse_start(16'h1234, 10'd0);
        repeat (2) @(negedge clk);
        chk("zero_done", n_done, 1);
        chk("zero_busrq", rq_seen, 0);
        chk("zero_ce", qa.size(), 0);
        chk("zero_busy_after", busy, 0);

        // normal 384-byte transfer
        clear_mon();
        pulse_start(16'h7000, 10'd384);
        wait_done("norm_done_seen", 5000);
        chk("norm_ce_count", qa.size(), 384);
        for (int i = 0; i < qa.size() && i < 384; i++) begin
            chk($sformatf("norm_addr[%0d]", i), qa[i], i);
            chk($sformatf("norm_src[%0d]", i), qs[i], 32'h7000 + i);
            chk($sformatf("norm_data[%0d]", i), qd[i], mem(16'h7000 + 16'(i)));
        end
        repeat (3) @(negedge clk);
        chk("norm_done_count", n_done, 1);
        chk("norm_busrq_released", busrq_n, 1);
        chk("norm_busy_after", busy, 0);

        // bus acknowledge never arrives
        clear_mon();
        busak_force = 1'b1;
        pulse_start(16'h0100, 10'd10);
        wait_done("tmo_done_seen", 3000);
        chk("tmo_abort_count", n_abort, 1);
        chk("tmo_slots", slot_at_abort, 255);
        chk("tmo_ce_count", qa.size(), 0);
        chk("tmo_done_count", n_done, 1);
        busak_force = 1'b0;

        // start while busy is ignored
        clear_mon();
        pulse_start(16'h2000, 10'd20);
        repeat (40) @(posedge clk);
        pulse_start(16'h3000, 10'd50);
        wait_done("busy_done_seen", 2000);
        repeat (2) @(negedge clk);
        chk("busy_ce_count", qa.size(), 20);
        if (qa.size() == 20) begin
            chk("busy_last_src", qs[19], 16'h2013);
            chk("busy_last_addr", qa[19], 19);
        end
        chk("busy_done_count", n_done, 1);

        // wrap-around on both address counters
        clear_mon();
        @(posedge clk);
        #1 src_base = 16'hFFFF; len = 10'd4; start_w = 1'b1;
        @(posedge clk);
        #1 start_w = 1'b0;
        begin
            int c = 0;
            while (wn_done < 1 && c < 500) begin
                @(posedge clk);
                c++;
            end
        end
        @(negedge clk);
        chk("wrap_done", wn_done, 1);
        chk("wrap_ce_count", wqa.size(), 4);
        for (int i = 0; i < wqa.size() && i < 4; i++) begin
            chk($sformatf("wrap_addr[%0d]", i), wqa[i], wa_exp[i]);
            chk($sformatf("wrap_src[%0d]", i), wqs[i], ws_exp[i]);
            chk($sformatf("wrap_data[%0d]", i), wqd[i], mem(ws_exp[i]));
        end

        // reset in the middle of a transfer
        clear_mon();
        pulse_start(16'h4000, 10'd100);
        begin
            int c = 0;
            while (qa.size() < 10 && c < 2000) begin
                @(posedge clk);
                c++;
            end
        end
        chk("mid_ce_before_rst", qa.size(), 10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busrq_n", busrq_n, 1);
        chk("mid_busy", busy, 0);
        chk("mid_rd_n", rd_n, 1);
        repeat (3) @(posedge clk);
        chk("mid_no_done", n_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        src_base = 16'h5000; len = 10'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("post_rst_accept", busy, 1);
        wait_done("post_done_seen", 500);
        chk("post_ce_count", qa.size(), 5);
        for (int i = 0; i < qa.size() && i < 5; i++) begin
            chk($sformatf("post_addr[%0d]", i), qa[i], i);
            chk($sformatf("post_src[%0d]", i), qs[i], 32'h5000 + i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dkong3_obj_dma.md
DKONG3_OBJ_DMA -- requirements
Module: dkong3_obj_dma

Interface
REQ-001 The parameter list SHALL be: DST_BASE, 10'h000, first object-RAM byte address written by a transfer.
REQ-002 The parameter list SHALL also include: REQ_TIMEOUT, 8'd255, maximum number of slots spent waiting for bus acknowledge before abort.
REQ-003 The ports SHALL be, in order:
- I_CLK_24M  in  1  system clock; all state is on its rising edge.
- RST_4L  in  1  reset, asynchronous, active-low.
- I_SLOT_CE  in  1  byte-slot clock enable, one I_CLK_24M cycle wide.
- I_START  in  1  transfer request pulse (CPU trigger write).
- I_SRC_BASE  in  16  source start address.
- I_LEN  in  10  byte count; 0 means no transfer.
- I_BUSAK_n  in  1  CPU bus acknowledge, active-low.
- O_BUSRQ_n  out  1  CPU bus request, active-low.
- O_SRC_A  out  16  source address.
- O_SRC_RD_n  out  1  source read strobe, active-low.
- I_SRC_D  in  8  source read data.
- O_OBJ_DMA_A  out  10  object-RAM write address.
- O_OBJ_DMA_D  out  8  object-RAM write data.
- O_OBJ_DMA_CE  out  1  object-RAM write enable, one-cycle pulse.
- O_BUSY  out  1  transfer in progress.
- O_DONE  out  1  completion pulse.
- O_ABORT  out  1  timeout pulse.

Function
REQ-004 The FSM SHALL have the states IDLE, REQ, READ, WRITE, RELEASE and FIN.
REQ-005 IDLE: an I_START pulse with I_LEN != 0 SHALL latch the source address, I_LEN and DST_BASE into internal counters and move to REQ on the next edge. This transition does not wait for I_SLOT_CE.
REQ-006 IDLE: an I_START pulse with I_LEN = 0 SHALL go directly to FIN; O_BUSRQ_n SHALL never assert.
REQ-007 I_START SHALL be ignored in every state except IDLE.
REQ-008 REQ: O_BUSRQ_n SHALL be low. On an I_SLOT_CE cycle with I_BUSAK_n low, the FSM SHALL move to READ.
REQ-009 REQ: on each I_SLOT_CE cycle with I_BUSAK_n high, an 8-bit wait counter SHALL increment. When the counter equals REQ_TIMEOUT, the FSM SHALL move to RELEASE and O_ABORT SHALL pulse for 1 cycle.
REQ-010 READ: O_SRC_A SHALL carry the source counter and O_SRC_RD_n SHALL be low for exactly one slot. On the I_SLOT_CE edge ending the slot, I_SRC_D SHALL be registered into O_OBJ_DMA_D and the FSM SHALL move to WRITE.
REQ-011 WRITE SHALL last exactly one I_CLK_24M cycle, during which O_OBJ_DMA_CE = 1 and O_OBJ_DMA_A = the destination counter.
REQ-012 On the edge leaving WRITE:
- source counter +1, wrapping modulo 2^16;
- destination counter +1, wrapping modulo 1024;
- remaining count -1.
REQ-013 The exit from WRITE SHALL be to READ if the remaining count was > 1, otherwise to RELEASE.
REQ-014 Throughput SHALL be one byte per I_SLOT_CE period. The write for byte n SHALL occur 1 cycle after the slot edge that captured byte n.
REQ-015 RELEASE: O_BUSRQ_n SHALL be high. The FSM SHALL move to FIN on the first cycle with I_BUSAK_n high.
REQ-016 FIN: O_DONE SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE. After a timeout, O_DONE SHALL still pulse.
REQ-017 O_BUSY SHALL be 1 in every state except IDLE.
REQ-018 O_SRC_RD_n SHALL be 1 outside READ. O_OBJ_DMA_CE SHALL be 0 outside WRITE.
REQ-019 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-020 If I_BUSAK_n goes high during READ or WRITE, the current byte SHALL complete and the FSM SHALL then go to RELEASE, ending the transfer early. No further reads SHALL occur.

Reset
REQ-021 RST_4L low SHALL immediately force:
- state = IDLE; all counters = 0;
- O_BUSRQ_n = 1, O_SRC_RD_n = 1;
- O_OBJ_DMA_CE = 0, O_BUSY = 0, O_DONE = 0, O_ABORT = 0;
- O_SRC_A = 0, O_OBJ_DMA_A = 0, O_OBJ_DMA_D = 0.
REQ-022 Reset asserted mid-transfer SHALL abandon the transfer with no DONE pulse. Bytes already written SHALL remain written.
REQ-023 After RST_4L rises, the block SHALL accept I_START on the first clock edge.

Verification
REQ-024 The bench SHALL cover at least these scenarios:
- Normal transfer: I_SRC_BASE = 16'h7000, I_LEN = 384, immediate BUSAK, I_SLOT_CE every 8 cycles → 384 CE pulses; O_OBJ_DMA_A 0..383; O_SRC_A 7000..717F; data matches; one DONE pulse; BUSRQ_n released.
- Zero length: I_LEN = 0 → O_BUSRQ_n stays 1, no CE, DONE 2 cycles after START.
- Timeout: I_BUSAK_n held high → O_ABORT after 255 slots, then DONE, 0 CE pulses.
- Wrap-around: DST_BASE = 10'h3FE, I_LEN = 4, I_SRC_BASE = 16'hFFFF → destination addresses 3FE, 3FF, 000, 001; source addresses FFFF, 0000, 0001, 0002.
- START while busy: second I_START mid-transfer ignored; exactly I_LEN writes occur.
- Reset mid-transfer: RST_4L low after byte 10 → BUSRQ_n = 1 the same cycle, no DONE; a new START after reset transfers correctly from DST_BASE.
